// File: rtl/quad_decoder.sv
// x4 quadrature decoder: 2-flop synchronizers, optional per-phase glitch filter
// (compiled in with QUAD_GLITCH_FILTER_EN), and an up/down position counter.
module quad_decoder #(
   parameter int unsigned N        = 8,
   parameter int unsigned FILT_LEN = 3
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         en,
   input  logic         clr,
   input  logic         err_clr,
   input  logic         a_in,
   input  logic         b_in,
   output logic [N-1:0] pos,
   output logic         dir,
   output logic         step,
   output logic         err
);

`ifdef QUAD_GLITCH_FILTER_EN
   localparam int unsigned PIPE_LEN = 2 + FILT_LEN;
`else
   localparam int unsigned PIPE_LEN = 2;
`endif
   // Sized for the deepest pipeline so the counter fits either build.
   localparam int unsigned INIT_W = $clog2(3 + FILT_LEN);

   typedef enum logic {
      S_INIT,
      S_TRACK
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [INIT_W-1:0]   r_init_cnt;
   logic [INIT_W-1:0]   w_init_cnt_nxt;
   logic [1:0]          r_sync1;
   logic [1:0]          r_sync2;
   logic [1:0]          w_ab;
   logic [1:0]          r_prev_ab;
   logic [1:0]          w_prev_ab_nxt;
   logic [1:0]          w_delta;
   logic [N-1:0]        r_pos;
   logic [N-1:0]        w_pos_nxt;
   logic                r_dir;
   logic                w_dir_nxt;
   logic                r_step;
   logic                w_step_nxt;
   logic                r_err;
   logic                w_err_nxt;

   // Position of an {a,b} pair along the up sequence 00 -> 10 -> 11 -> 01.
   function automatic logic [1:0] phase_idx(input logic [1:0] ab);
      case (ab)
         2'b00:   phase_idx = 2'd0;
         2'b10:   phase_idx = 2'd1;
         2'b11:   phase_idx = 2'd2;
         default: phase_idx = 2'd3;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sync1 <= 2'b00;
         r_sync2 <= 2'b00;
      end else begin
         r_sync1 <= {a_in, b_in};
         r_sync2 <= r_sync1;
      end
   end

`ifdef QUAD_GLITCH_FILTER_EN
   localparam int unsigned FCNT_W = 4;

   logic [1:0]             r_filt;
   logic [1:0][FCNT_W-1:0] r_fcnt;

   // A phase flips only after FILT_LEN consecutive samples disagree with it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_filt <= 2'b00;
         r_fcnt <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] != r_filt[i]) begin
               if (r_fcnt[i] == FCNT_W'(FILT_LEN - 1)) begin
                  r_filt[i] <= r_sync2[i];
                  r_fcnt[i] <= '0;
               end else begin
                  r_fcnt[i] <= r_fcnt[i] + FCNT_W'(1);
               end
            end else begin
               r_fcnt[i] <= '0;
            end
         end
      end
   end

   assign w_ab = r_filt;
`else
   assign w_ab = r_sync2;
`endif

   // 1 = one step up, 3 = one step down, 2 = both phases changed.
   assign w_delta = phase_idx(w_ab) - phase_idx(r_prev_ab);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= S_INIT;
         r_init_cnt <= '0;
         r_prev_ab  <= 2'b00;
         r_pos      <= '0;
         r_dir      <= 1'b0;
         r_step     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_init_cnt <= w_init_cnt_nxt;
         r_prev_ab  <= w_prev_ab_nxt;
         r_pos      <= w_pos_nxt;
         r_dir      <= w_dir_nxt;
         r_step     <= w_step_nxt;
         r_err      <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_init_cnt_nxt = r_init_cnt;
      w_prev_ab_nxt  = r_prev_ab;
      w_pos_nxt      = r_pos;
      w_dir_nxt      = r_dir;
      w_step_nxt     = 1'b0;
      w_err_nxt      = r_err & ~err_clr;

      case (r_state)
         S_INIT: begin
            // Wait for the sync/filter pipeline to hold real pin values.
            if (r_init_cnt == INIT_W'(PIPE_LEN)) begin
               w_state_nxt   = S_TRACK;
               w_prev_ab_nxt = w_ab;
            end else begin
               w_init_cnt_nxt = r_init_cnt + INIT_W'(1);
            end
         end
         S_TRACK: begin
            w_prev_ab_nxt = w_ab;
            case (w_delta)
               2'd1: begin
                  if (en) begin
                     w_pos_nxt  = r_pos + N'(1);
                     w_dir_nxt  = 1'b1;
                     w_step_nxt = 1'b1;
                  end
               end
               2'd3: begin
                  if (en) begin
                     w_pos_nxt  = r_pos - N'(1);
                     w_dir_nxt  = 1'b0;
                     w_step_nxt = 1'b1;
                  end
               end
               2'd2:    w_err_nxt = 1'b1;
               default: ;
            endcase
         end
         default: w_state_nxt = S_INIT;
      endcase

      if (clr) w_pos_nxt = '0;
   end

   assign pos  = r_pos;
   assign dir  = r_dir;
   assign step = r_step;
   assign err  = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed scenarios plus randomized
// encoder motion checked against a sample-history reference model.
module tb_quad_decoder;

   localparam int FL = 3;
`ifdef QUAD_GLITCH_FILTER_EN
   localparam int LAT = 2 + FL;
`else
   localparam int LAT = 2;
`endif

   logic       clk;
   logic       rstn;
   logic       en;
   logic       clr;
   logic       err_clr;
   logic       a_in;
   logic       b_in;
   logic [7:0] pos8;
   logic       dir8;
   logic       step8;
   logic       err8;
   logic [1:0] pos2;
   logic       dir2;
   logic       step2;
   logic       err2;

   int n_checks = 0;
   int n_errors = 0;

   quad_decoder #(.N(8), .FILT_LEN(FL)) u_dut8 (
      .clk(clk), .rstn(rstn), .en(en), .clr(clr), .err_clr(err_clr),
      .a_in(a_in), .b_in(b_in), .pos(pos8), .dir(dir8), .step(step8), .err(err8)
   );

   quad_decoder #(.N(2), .FILT_LEN(FL)) u_dut2 (
      .clk(clk), .rstn(rstn), .en(en), .clr(clr), .err_clr(err_clr),
      .a_in(a_in), .b_in(b_in), .pos(pos2), .dir(dir2), .step(step2), .err(err2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [1:0] up_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
   logic [1:0] hist [$];
   int         m_ec;
   int         m_cnt;
   int         m_d;
   logic [1:0] m_cur;
   logic [1:0] m_prev;
   logic [1:0] m_filt;
   logic [1:0] m_smp;
   logic       m_flip;
   logic       m_track;
   logic       m_dir;
   logic       m_step;
   logic       m_err;

   function automatic int idx(input logic [1:0] ab);
      int r = 0;
      for (int i = 0; i < 4; i++) if (up_seq[i] == ab) r = i;
      return r;
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hist = {};
         m_ec = 0; m_cnt = 0; m_prev = 2'b00; m_filt = 2'b00; m_track = 1'b0;
         m_dir = 1'b0; m_step = 1'b0; m_err = 1'b0;
      end else begin
         hist.push_front({a_in, b_in});
         if (hist.size() > 20) void'(hist.pop_back());
         m_ec++;
         m_step = 1'b0;
`ifdef QUAD_GLITCH_FILTER_EN
         m_cur = m_filt;
         for (int i = 0; i < 2; i++) begin
            m_flip = 1'b1;
            for (int k = 2; k <= FL + 1; k++) begin
               m_smp = (m_ec > k) ? hist[k] : 2'b00;
               if (m_smp[i] == m_filt[i]) m_flip = 1'b0;
            end
            if (m_flip) m_filt[i] = ~m_filt[i];
         end
`else
         m_cur = (m_ec > 2) ? hist[2] : 2'b00;
`endif
         if (err_clr) m_err = 1'b0;
         if (m_track) begin
            m_d = (idx(m_cur) - idx(m_prev) + 4) % 4;
            if (m_d == 1 && en) begin m_cnt++; m_dir = 1'b1; m_step = 1'b1; end
            if (m_d == 3 && en) begin m_cnt--; m_dir = 1'b0; m_step = 1'b1; end
            if (m_d == 2) m_err = 1'b1;
            m_prev = m_cur;
         end else if (m_ec == LAT + 1) begin
            m_prev  = m_cur;
            m_track = 1'b1;
         end
         if (clr) m_cnt = 0;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input logic [1:0] ab);
      {a_in, b_in} = ab;
      en = 1'b1; clr = 1'b0; err_clr = 1'b0;
      rstn = 1'b0;
      tick(); tick();
      rstn = 1'b1;
      repeat (LAT + 4) tick();
   endtask

   task automatic move(input logic [1:0] ab);
      {a_in, b_in} = ab;
      repeat (LAT + 2) tick();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      {a_in, b_in} = 2'b00;
      en = 1'b1; clr = 1'b0; err_clr = 1'b0;
      rstn = 1'b1;
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      n_checks++;
      if ({pos8, dir8, step8, err8} !== 11'd0 || {pos2, dir2, step2, err2} !== 5'd0) begin
         n_errors++;
         $display("FAIL reset_values: got pos8=%0h dir=%b step=%b err=%b pos2=%0h expected all zero",
                  pos8, dir8, step8, err8, pos2);
      end
      @(negedge clk);
      rstn = 1'b1;
      repeat (LAT + 4) tick();
   endtask

   task automatic test_hold11();
      int steps = 0;
      int errs  = 0;
      do_reset(2'b11);
      for (int i = 0; i < 10; i++) begin
         tick();
         if (step8) steps++;
         if (err8) errs++;
      end
      n_checks++;
      if (steps != 0 || errs != 0 || pos8 !== 8'd0) begin
         n_errors++;
         $display("FAIL hold11: got steps=%0d errs=%0d pos=%0d expected 0 0 0", steps, errs, pos8);
      end
      // 11 -> 01 is one step up only if INIT captured 11 as the previous pair.
      move(2'b01);
      n_checks++;
      if (pos8 !== 8'd1 || dir8 !== 1'b1 || err8 !== 1'b0) begin
         n_errors++;
         $display("FAIL hold11_prev: got pos=%0d dir=%b err=%b expected 1 1 0", pos8, dir8, err8);
      end
   endtask

   task automatic test_up_seq();
      logic [1:0] seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
      do_reset(2'b00);
      for (int p = 0; p < 4; p++) begin
         {a_in, b_in} = seq[p];
         for (int t = 1; t <= LAT + 2; t++) begin
            tick();
            n_checks++;
            if (step8 !== (t == LAT + 1)) begin
               n_errors++;
               $display("FAIL up_seq_step: phase %0d cycle %0d got %b expected %b",
                        p, t, step8, (t == LAT + 1));
            end
         end
      end
      n_checks++;
      if (pos8 !== 8'd4 || dir8 !== 1'b1 || err8 !== 1'b0) begin
         n_errors++;
         $display("FAIL up_seq_pos: got pos=%0d dir=%b err=%b expected 4 1 0", pos8, dir8, err8);
      end
   endtask

   task automatic test_wrap();
      do_reset(2'b00);
      move(2'b01);
      n_checks++;
      if (pos2 !== 2'd3 || dir2 !== 1'b0 || pos8 !== 8'd255) begin
         n_errors++;
         $display("FAIL wrap_down: got pos2=%0d dir2=%b pos8=%0d expected 3 0 255", pos2, dir2, pos8);
      end
      move(2'b00); move(2'b10); move(2'b11); move(2'b01);
      n_checks++;
      if (pos2 !== 2'd3 || dir2 !== 1'b1 || pos8 !== 8'd3) begin
         n_errors++;
         $display("FAIL wrap_up: got pos2=%0d dir2=%b pos8=%0d expected 3 1 3", pos2, dir2, pos8);
      end
   endtask

   task automatic test_illegal();
      do_reset(2'b00);
      move(2'b11);
      n_checks++;
      if (err8 !== 1'b1 || pos8 !== 8'd0 || dir8 !== 1'b0) begin
         n_errors++;
         $display("FAIL illegal_set: got err=%b pos=%0d dir=%b expected 1 0 0", err8, pos8, dir8);
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      n_checks++;
      if (err8 !== 1'b0) begin
         n_errors++;
         $display("FAIL err_clr_alone: got err=%b expected 0", err8);
      end
      {a_in, b_in} = 2'b00;
      repeat (LAT) tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      n_checks++;
      if (err8 !== 1'b1 || pos8 !== 8'd0) begin
         n_errors++;
         $display("FAIL err_clr_vs_illegal: got err=%b pos=%0d expected 1 0", err8, pos8);
      end
   endtask

   task automatic test_enable_clr();
      do_reset(2'b00);
      en = 1'b0;
      move(2'b10); move(2'b11); move(2'b01);
      n_checks++;
      if (pos8 !== 8'd0 || dir8 !== 1'b0) begin
         n_errors++;
         $display("FAIL en_low: got pos=%0d dir=%b expected 0 0", pos8, dir8);
      end
      en = 1'b1;
      move(2'b00);
      n_checks++;
      if (pos8 !== 8'd1 || dir8 !== 1'b1) begin
         n_errors++;
         $display("FAIL en_resume: got pos=%0d dir=%b expected 1 1", pos8, dir8);
      end
      {a_in, b_in} = 2'b10;
      repeat (LAT) tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      n_checks++;
      if (pos8 !== 8'd0 || step8 !== 1'b1 || dir8 !== 1'b1) begin
         n_errors++;
         $display("FAIL clr_with_step: got pos=%0d step=%b dir=%b expected 0 1 1", pos8, step8, dir8);
      end
      tick();
      n_checks++;
      if (step8 !== 1'b0 || pos8 !== 8'd0) begin
         n_errors++;
         $display("FAIL clr_after: got step=%b pos=%0d expected 0 0", step8, pos8);
      end
   endtask

   task automatic test_random();
      logic [1:0] ab = 2'b00;
      int r;
      int hold;
      do_reset(2'b00);
      for (int it = 0; it < 300; it++) begin
         r = int'($urandom_range(0, 9));
         if (r < 4)       ab = up_seq[(idx(ab) + 1) % 4];
         else if (r < 8)  ab = up_seq[(idx(ab) + 3) % 4];
         else if (r == 8) ab = up_seq[(idx(ab) + 2) % 4];
         {a_in, b_in} = ab;
         hold = int'($urandom_range(2, 5));
         for (int c = 0; c < hold; c++) begin
            en      = ($urandom_range(0, 4) != 0);
            clr     = ($urandom_range(0, 29) == 0);
            err_clr = ($urandom_range(0, 9) == 0);
            tick();
            n_checks++;
            if ({pos8, dir8, step8, err8} !== {8'(m_cnt), m_dir, m_step, m_err} ||
                {pos2, dir2, step2, err2} !== {2'(m_cnt), m_dir, m_step, m_err}) begin
               n_errors++;
               $display("FAIL random_it%0d: got pos8=%0d pos2=%0d dir=%b step=%b err=%b expected pos=%0d dir=%b step=%b err=%b",
                        it, pos8, pos2, dir8, step8, err8, 8'(m_cnt), m_dir, m_step, m_err);
            end
         end
      end
      en = 1'b1; clr = 1'b0; err_clr = 1'b0;
   endtask

   task automatic test_reset_midmotion();
      int bad = 0;
      do_reset(2'b00);
      move(2'b10); move(2'b11);
      {a_in, b_in} = 2'b01;
      tick();
      #2 rstn = 1'b0;
      #1;
      n_checks++;
      if ({pos8, dir8, step8, err8} !== 11'd0) begin
         n_errors++;
         $display("FAIL midmotion_async: got pos=%0d dir=%b step=%b err=%b expected all zero",
                  pos8, dir8, step8, err8);
      end
      {a_in, b_in} = 2'b10;
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (step8 !== 1'b0 || err8 !== 1'b0 || pos8 !== 8'd0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_errors++;
         $display("FAIL midmotion_quiet: got %0d bad cycles expected 0", bad);
      end
      move(2'b11);
      n_checks++;
      if (pos8 !== 8'd1 || dir8 !== 1'b1 || err8 !== 1'b0) begin
         n_errors++;
         $display("FAIL midmotion_resume: got pos=%0d dir=%b err=%b expected 1 1 0", pos8, dir8, err8);
      end
   endtask

`ifdef QUAD_GLITCH_FILTER_EN
   task automatic test_glitch();
      int steps = 0;
      do_reset(2'b00);
      a_in = 1'b1;
      tick(); tick();
      a_in = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (step8) steps++;
      end
      n_checks++;
      if (steps != 0 || pos8 !== 8'd0) begin
         n_errors++;
         $display("FAIL glitch_reject: got steps=%0d pos=%0d expected 0 0", steps, pos8);
      end
      a_in = 1'b1;
      for (int t = 1; t <= LAT + 2; t++) begin
         tick();
         n_checks++;
         if (step8 !== (t == LAT + 1)) begin
            n_errors++;
            $display("FAIL glitch_accept: cycle %0d got %b expected %b", t, step8, (t == LAT + 1));
         end
      end
      n_checks++;
      if (pos8 !== 8'd1) begin
         n_errors++;
         $display("FAIL glitch_pos: got %0d expected 1", pos8);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_hold11();
      test_up_seq();
      test_wrap();
      test_illegal();
      test_enable_clr();
      test_random();
      test_reset_midmotion();
`ifdef QUAD_GLITCH_FILTER_EN
      test_glitch();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
